lfsr_stream: RTL and testbench

Parametrised Galois LFSR pseudo-random source with a one-entry valid/ready output buffer, runtime seed loading, period detection and optional zero-seed lockup recovery. Next generation of the fixed 32-bit free-running LFSR. It feeds pseudo-random words to downstream consumers that can apply back-pressure. It also exposes the full register state for the top-level pin mux.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr_stream_if.sv | 22 ++
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_stream.sv | 105 ++++++++++
 tb/tb_lfsr_stream.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and tap constants for the LFSR stream generators.
package lfsr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Maximal-length Galois feedback masks for common widths.
  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready word stream carrying LFSR output words to a consumer.
interface lfsr_stream_if #(
  parameter int OUT_W = 16
);

  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] out_data_o;

  modport master (
    output out_valid_o,
    output out_data_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_data_o,
    output out_ready_i
  );

endinterface

// File: rtl/lfsr_step.sv
// Combinational Galois LFSR next-state function; reusable by other generators.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = state_i[0] ? ((state_i >> 1) ^ TAPS) : (state_i >> 1);

endmodule

// File: rtl/lfsr_stream.sv
// Galois LFSR word source with a one-entry valid/ready buffer, seed loading and
// period detection. Define LFSR_STREAM_LOCKUP_EN to replace zero seeds with SEED.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               OUT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               seed_valid_i,
  input  logic [WIDTH-1:0]   seed_i,
  lfsr_stream_if.master      stream,
  output logic [WIDTH-1:0]   state_o,
  output logic               period_o,
  output logic [WIDTH-1:0]   period_len_o,
  output logic               lockup_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  buf_state_e       buf_q, buf_d;
  logic [WIDTH-1:0] state_q, seed_q, count_q;
  logic [WIDTH-1:0] next_state, load_value;
  logic             step, load_zero;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state_i (state_q),
    .next_o  (next_state)
  );

  // A full buffer only advances when the consumer takes the current word.
  assign step = en_i && !seed_valid_i && ((buf_q == EMPTY) || stream.out_ready_i);

`ifdef LFSR_STREAM_LOCKUP_EN
  assign load_zero  = (seed_i == '0);
  assign load_value = load_zero ? SEED : seed_i;
`else
  assign load_zero  = 1'b0;
  assign load_value = seed_i;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives buf_d; no latch is inferred.
    buf_d = buf_q;
    if (seed_valid_i) begin
      buf_d = EMPTY;
    end else if (step) begin
      buf_d = FULL;
    end else if ((buf_q == FULL) && stream.out_ready_i) begin
      buf_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      buf_q <= EMPTY;
    end else begin
      buf_q <= buf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= SEED;
      seed_q            <= SEED;
      count_q           <= '0;
      stream.out_data_o <= '0;
      period_o          <= 1'b0;
      period_len_o      <= '0;
      lockup_o          <= 1'b0;
    end else begin
      period_o <= 1'b0;
      lockup_o <= 1'b0;
      if (seed_valid_i) begin
        state_q  <= load_value;
        seed_q   <= load_value;
        count_q  <= '0;
        lockup_o <= load_zero;
      end else if (step) begin
        state_q           <= next_state;
        stream.out_data_o <= next_state[OUT_W-1:0];
        // Returning to the loaded seed closes one period.
        if (next_state == seed_q) begin
          period_o     <= 1'b1;
          period_len_o <= count_q + ONE;
          count_q      <= '0;
        end else begin
          count_q <= count_q + ONE;
        end
      end
    end
  end

  assign stream.out_valid_o = (buf_q == FULL);
  assign state_o            = state_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream (4-bit build): directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_lfsr_stream;

  localparam int           W    = 4;
  localparam logic [W-1:0] TAPS = 4'hC;
  localparam logic [W-1:0] SEED = 4'h1;
`ifdef LFSR_STREAM_LOCKUP_EN
  localparam bit LOCKUP = 1'b1;
`else
  localparam bit LOCKUP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, en, seed_valid;
  logic [W-1:0] seed, state, plen;
  logic         period, lockup;

  lfsr_stream_if #(.OUT_W(W)) bus ();

  lfsr_stream #(
    .WIDTH (W),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .OUT_W (W)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .en_i         (en),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .stream       (bus),
    .state_o      (state),
    .period_o     (period),
    .period_len_o (plen),
    .lockup_o     (lockup)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference step written as plain integer arithmetic.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] s);
    int v;
    v = int'(s);
    return W'((v / 2) ^ ((v % 2) * int'(TAPS)));
  endfunction

  // Behavioural model of the observable outputs after the coming edge.
  logic [W-1:0] m_state, m_seed, m_count, m_data, m_plen;
  logic         m_valid, m_period, m_lock;

  task automatic model_step(input bit rst, input bit e, input bit sv,
                            input logic [W-1:0] sd, input bit rdy);
    logic [W-1:0] nx;
    m_period = 1'b0;
    m_lock   = 1'b0;
    if (rst) begin
      m_state = SEED; m_seed = SEED; m_count = '0; m_data = '0;
      m_plen  = '0;   m_valid = 1'b0;
    end else if (sv) begin
      if (LOCKUP && sd == '0) begin
        m_state = SEED; m_seed = SEED; m_lock = 1'b1;
      end else begin
        m_state = sd; m_seed = sd;
      end
      m_count = '0;
      m_valid = 1'b0;
    end else if (e && (!m_valid || rdy)) begin
      nx      = ref_next(m_state);
      m_state = nx;
      m_data  = nx;
      m_valid = 1'b1;
      if (nx == m_seed) begin
        m_period = 1'b1;
        m_plen   = W'(int'(m_count) + 1);
        m_count  = '0;
      end else begin
        m_count = W'(int'(m_count) + 1);
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("valid",      bus.out_valid_o, m_valid);
    check("data",       bus.out_data_o,  m_data);
    check("state",      state,           m_state);
    check("period",     period,          m_period);
    check("period_len", plen,            m_plen);
    check("lockup",     lockup,          m_lock);
  endtask

  task automatic drive(input bit rst, input bit e, input bit sv,
                       input logic [W-1:0] sd, input bit rdy);
    reset = rst; en = e; seed_valid = sv; seed = sd; bus.out_ready_i = rdy;
    model_step(rst, e, sv, sd, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  logic [W-1:0] first_words [4] = '{4'hC, 4'h6, 4'h3, 4'hD};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held_data, held_state, d1;

    // Reset state
    drive(1, 0, 0, '0, 0);
    drive(1, 0, 0, '0, 0);
    check("rst_state", state, SEED);
    check("rst_valid", bus.out_valid_o, 0);

    // Free-running sequence and first period
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 0, '0, 1);
      if (i < 4) check("seq_word", bus.out_data_o, first_words[i]);
      if (i == 14) begin
        check("period_pulse", period, 1);
        check("period_len15", plen, 15);
      end else begin
        check("no_period", period, 0);
      end
    end

    // Back-pressure: everything holds, then the stream resumes without gaps
    held_data  = bus.out_data_o;
    held_state = state;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, '0, 0);
      check("stall_valid", bus.out_valid_o, 1);
      check("stall_data",  bus.out_data_o,  held_data);
      check("stall_state", state,           held_state);
    end
    drive(0, 1, 0, '0, 1);
    check("release_word1", bus.out_data_o, ref_next(held_state));
    drive(0, 1, 0, '0, 1);
    check("release_word2", bus.out_data_o, ref_next(ref_next(held_state)));

    // Seed load while full and stalled
    drive(0, 1, 0, '0, 0);
    drive(0, 1, 1, 4'h9, 0);
    check("seed_state", state, 4'h9);
    check("seed_valid", bus.out_valid_o, 0);
    drive(0, 1, 0, '0, 1);
    check("seed_word", bus.out_data_o, 4'h8);

    // Zero seed
    drive(0, 0, 1, 4'h0, 0);
`ifdef LFSR_STREAM_LOCKUP_EN
    check("zero_recover_state", state, SEED);
    check("zero_lockup_pulse", lockup, 1);
    drive(0, 0, 0, '0, 0);
    check("zero_lockup_once", lockup, 0);
`else
    check("zero_state", state, 0);
    check("zero_no_lockup", lockup, 0);
    drive(0, 1, 0, '0, 1);
    check("zero_stuck", state, 0);
    check("zero_period", period, 1);
    check("zero_period_len", plen, 1);
`endif
    drive(0, 0, 1, SEED, 0);

    // en toggled 1,0,1 with ready high
    drive(0, 1, 0, '0, 1);
    d1 = bus.out_data_o;
    check("en1_valid", bus.out_valid_o, 1);
    drive(0, 0, 0, '0, 1);
    check("en0_valid", bus.out_valid_o, 0);
    check("en0_state", state, d1);
    drive(0, 1, 0, '0, 1);
    check("en1b_valid", bus.out_valid_o, 1);
    check("en1b_word", bus.out_data_o, ref_next(d1));

    // Reset mid-stream while full
    drive(0, 1, 0, '0, 0);
    check("pre_rst_full", bus.out_valid_o, 1);
    drive(1, 1, 0, '0, 1);
    check("mid_rst_valid", bus.out_valid_o, 0);
    check("mid_rst_data", bus.out_data_o, 0);
    check("mid_rst_state", state, SEED);
    check("mid_rst_period", period, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0,
            W'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
